// File: rtl/kernel_pkg.sv
// ---------------------------------------------------------------------------
// kernel_pkg
// Purpose : shared constants and FSM state type for the kernel stream reader.
// Contents: DEPTH  - kernel memory entries
//           ADDR_W - kernel memory address width
//           LEN_W  - width of the requested kernel length
//           kernel_state_t - reader FSM states
// ---------------------------------------------------------------------------
package kernel_pkg;

  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;
  localparam int LEN_W  = 6;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREFETCH = 2'd1,
    ST_STREAM   = 2'd2,
    ST_FINISH   = 2'd3
  } kernel_state_t;

endpackage

// File: rtl/kernel_address_counter_module.sv
// ---------------------------------------------------------------------------
// kernel_address_counter_module
// Purpose : registered read-address counter for the kernel memory.
//           Clear has priority over increment; increment wraps naturally at
//           the top of the address range. o_term flags that the current
//           address equals the terminal index (length - 1).
// Ports   : i_clk, i_rst_n   - clock, async active-low reset
//           i_clear          - load address 0
//           i_inc            - advance address by one
//           i_term_idx       - terminal index for compare
//           o_addr           - registered address
//           o_term           - o_addr == i_term_idx
// ---------------------------------------------------------------------------
module kernel_address_counter_module
  import kernel_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clear,
  input  logic              i_inc,
  input  logic [ADDR_W-1:0] i_term_idx,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_term
);

  logic [ADDR_W-1:0] r_addr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_addr <= '0;
    end else if (i_clear) begin
      r_addr <= '0;
    end else if (i_inc) begin
      // Rolls over from the top address to 0 by truncation.
      r_addr <= r_addr + ADDR_W'(1);
    end
  end

  assign o_addr = r_addr;
  assign o_term = (r_addr == i_term_idx);

endmodule

// File: rtl/kernel_stream_reader_module.sv
// ---------------------------------------------------------------------------
// kernel_stream_reader_module
// Purpose : streams a kernel of up to DEPTH words out of a memory with a
//           combinational read port onto a valid/ready output stream.
//           A one-cycle prefetch primes the output register; afterwards the
//           read address always runs one word ahead of OUT_DATA so a new
//           word can be loaded on every accepted transfer.
// Config  : KERNEL_READER_ABORT_EN adds i_abort, which returns any active
//           stream to idle on the next edge with no done pulse.
// Ports   : i_clk, i_rst_n   - clock, async active-low reset
//           i_start          - request to stream from address 0
//           i_kernel_len     - words to stream (sampled on accepted start)
//           o_rd_address     - kernel memory read address (registered)
//           i_rd_data        - combinational read data for o_rd_address
//           o_out_data       - streamed word (registered)
//           o_out_valid      - o_out_data valid
//           i_out_ready      - consumer accepts o_out_data
//           o_out_last       - o_out_data is the final word
//           o_busy           - FSM not idle
//           o_done           - one-cycle pulse after the final transfer
//           i_abort          - (KERNEL_READER_ABORT_EN only) cancel stream
//
// state       | meaning
// ------------+-------------------------------------------------------------
// ST_IDLE     | waiting for start with non-zero length
// ST_PREFETCH | address 0 on the read port; load word 0 into output register
// ST_STREAM   | output valid; load next word on each accepted transfer
// ST_FINISH   | final word accepted; pulse done, rewind address
// ---------------------------------------------------------------------------
module kernel_stream_reader_module #(
  parameter int DATA_SIZE = 24,
  parameter int DEPTH     = 32
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_start,
  input  logic [kernel_pkg::LEN_W-1:0]  i_kernel_len,
  output logic [kernel_pkg::ADDR_W-1:0] o_rd_address,
  input  logic [DATA_SIZE-1:0]          i_rd_data,
  output logic [DATA_SIZE-1:0]          o_out_data,
  output logic                          o_out_valid,
  input  logic                          i_out_ready,
  output logic                          o_out_last,
  output logic                          o_busy,
`ifdef KERNEL_READER_ABORT_EN
  input  logic                          i_abort,
`endif
  output logic                          o_done
);

  import kernel_pkg::*;

  kernel_state_t     r_state;
  logic [ADDR_W-1:0] r_len_m1;
  logic [DATA_SIZE-1:0] r_out_data;
  logic              r_out_valid;
  logic              r_out_last;

  logic              w_start_ok;
  logic [ADDR_W-1:0] w_len_m1;
  logic              w_xfer;
  logic              w_abort;
  logic              w_cnt_clear;
  logic              w_cnt_inc;
  logic              w_term;
  logic [ADDR_W-1:0] w_rd_addr;

`ifdef KERNEL_READER_ABORT_EN
  assign w_abort = i_abort && (r_state != ST_IDLE);
`else
  assign w_abort = 1'b0;
`endif

  assign w_start_ok = (r_state == ST_IDLE) && i_start && (i_kernel_len != '0);

  // Lengths of DEPTH and above all map to the last address; the stored value
  // is length-1 so it fits the address width and feeds the terminal compare.
  assign w_len_m1 = (i_kernel_len >= LEN_W'(DEPTH)) ? ADDR_W'(DEPTH - 1)
                                                    : i_kernel_len[ADDR_W-1:0] - ADDR_W'(1);

  assign w_xfer = r_out_valid && i_out_ready;

  // Address is already 0 in idle; clearing on accepted start keeps that
  // explicit and also covers the abort path.
  assign w_cnt_clear = w_start_ok || (r_state == ST_FINISH) || w_abort;
  assign w_cnt_inc   = (r_state == ST_PREFETCH) ||
                       ((r_state == ST_STREAM) && w_xfer && !r_out_last);

  kernel_address_counter_module u_addr_cnt (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clear    (w_cnt_clear),
    .i_inc      (w_cnt_inc),
    .i_term_idx (r_len_m1),
    .o_addr     (w_rd_addr),
    .o_term     (w_term)
  );

  // The read address equals the index of the word about to be loaded, so
  // the terminal compare on it decides o_out_last for that word.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_len_m1    <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else if (w_abort) begin
      r_state     <= ST_IDLE;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start_ok) begin
            r_len_m1 <= w_len_m1;
            r_state  <= ST_PREFETCH;
          end
        end
        ST_PREFETCH: begin
          r_out_data  <= i_rd_data;
          r_out_valid <= 1'b1;
          r_out_last  <= w_term;
          r_state     <= ST_STREAM;
        end
        ST_STREAM: begin
          if (w_xfer) begin
            if (r_out_last) begin
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
              r_state     <= ST_FINISH;
            end else begin
              r_out_data <= i_rd_data;
              r_out_last <= w_term;
            end
          end
        end
        ST_FINISH: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_rd_address = w_rd_addr;
  assign o_out_data   = r_out_data;
  assign o_out_valid  = r_out_valid;
  assign o_out_last   = r_out_last;
  assign o_busy       = (r_state != ST_IDLE);
  assign o_done       = (r_state == ST_FINISH);

endmodule

// File: tb/tb_kernel_stream_reader_module.sv
module tb_kernel_stream_reader_module;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  kernel_len = '0;
  logic [4:0]  rd_address;
  logic [23:0] rd_data;
  logic [23:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_last;
  logic        busy;
  logic        done;
  logic        abort_tb = 1'b0;

  logic [23:0] mem [32];

  kernel_stream_reader_module #(.DATA_SIZE(24), .DEPTH(32)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_kernel_len (kernel_len),
    .o_rd_address (rd_address),
    .i_rd_data    (rd_data),
    .o_out_data   (out_data),
    .o_out_valid  (out_valid),
    .i_out_ready  (out_ready),
    .o_out_last   (out_last),
    .o_busy       (busy),
`ifdef KERNEL_READER_ABORT_EN
    .i_abort      (abort_tb),
`endif
    .o_done       (done)
  );

  always #5 clk = ~clk;

  assign rd_data = mem[rd_address];

  typedef struct packed {
    logic [23:0] data;
    logic        last;
    logic [4:0]  idx;
  } exp_t;

  exp_t q[$];

  int n_pass = 0;
  int n_total = 0;
  int done_cnt = 0;
  int exp_done = 0;
  int cyc = 0;
  int last_xfer_cyc = -10;
  logic toggle_en = 1'b0;

  logic        prev_valid = 1'b0;
  logic        prev_ready = 1'b0;
  logic [23:0] prev_data = '0;
  logic        prev_last = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    if (toggle_en) out_ready = ~out_ready;
  end

  // Scoreboard monitor: every accepted word is compared against the queue.
  always @(negedge clk) begin
    exp_t e;
    logic [4:0] nxt;
    if (!rst_n) begin
      prev_valid = 1'b0;
      prev_ready = 1'b0;
    end else begin
      if (prev_valid && !prev_ready) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, prev_data);
        chk("stall_last", out_last, prev_last);
      end
      if (done) begin
        done_cnt++;
        chk("done_latency", cyc, last_xfer_cyc + 1);
      end
      if (out_valid && out_ready && !abort_tb) begin
        if (q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_word: got 0x%0h expected no word", out_data);
        end else begin
          e = q.pop_front();
          nxt = e.idx + 5'd1;
          chk("word_data", out_data, e.data);
          chk("word_last", out_last, e.last);
          chk("rd_addr_ahead", rd_address, nxt);
          if (out_last) last_xfer_cyc = cyc;
        end
      end
      prev_valid = out_valid;
      prev_ready = out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  // Push words 0..n-1 of a kernel of length len (last flag on index len-1).
  task automatic push_words(input int n, input int len);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.data = 24'h100 + 24'(i);
      e.last = (i == len - 1);
      e.idx  = 5'(i);
      q.push_back(e);
    end
  endtask

  task automatic start_pulse(input logic [5:0] len);
    @(posedge clk);
    #1 start = 1'b1;
    kernel_len = len;
    @(posedge clk);
    #1 start = 1'b0;
    kernel_len = 6'h2A;
  endtask

  task automatic wait_done(input int target, input int budget, input string name);
    int i;
    i = 0;
    while (done_cnt < target && i < budget) begin
      @(posedge clk);
      i++;
    end
    chk(name, (done_cnt >= target), 1);
  endtask

  task automatic settle(input string name);
    repeat (3) @(posedge clk);
    #1;
    chk({name, "_queue_empty"}, q.size(), 0);
    chk({name, "_done_count"}, done_cnt, exp_done);
    chk({name, "_busy_idle"}, busy, 0);
    chk({name, "_addr_zero"}, rd_address, 0);
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_addr"}, rd_address, 0);
    chk({name, "_data"}, out_data, 0);
    chk({name, "_valid"}, out_valid, 0);
    chk({name, "_last"}, out_last, 0);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_done"}, done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 24'h100 + 24'(i);

    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Basic stream, ready always high, with latency checks.
    out_ready = 1'b1;
    push_words(4, 4);
    start_pulse(6'd4);
    chk("prefetch_valid_low", out_valid, 0);
    chk("prefetch_busy", busy, 1);
    @(posedge clk);
    #1;
    chk("first_valid", out_valid, 1);
    chk("first_data", out_data, 24'h100);
    exp_done = 1;
    wait_done(1, 50, "len4_done");
    settle("len4");

    // Full 32-word kernel with ready toggling.
    out_ready = 1'b1;
    toggle_en = 1'b1;
    push_words(32, 32);
    start_pulse(6'd32);
    exp_done = 2;
    wait_done(2, 200, "len32_done");
    toggle_en = 1'b0;
    @(posedge clk);
    #2 out_ready = 1'b1;
    settle("len32");

    // Zero length ignored; start during an active stream ignored.
    start_pulse(6'd0);
    repeat (5) @(posedge clk);
    #1;
    chk("len0_busy", busy, 0);
    chk("len0_valid", out_valid, 0);
    chk("len0_done", done_cnt, exp_done);
    push_words(3, 3);
    start_pulse(6'd3);
    start_pulse(6'd5);
    exp_done = 3;
    wait_done(3, 50, "len3_done");
    settle("len3");

    // Length above DEPTH clamps to 32 words.
    push_words(32, 32);
    start_pulse(6'd40);
    exp_done = 4;
    wait_done(4, 100, "len40_done");
    settle("len40");

    // Reset mid-stream after word 2 has been accepted.
    push_words(3, 8);
    start_pulse(6'd8);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    chk("midreset_queue", q.size(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1;
    kernel_len = 6'd2;
    push_words(2, 2);
    @(posedge clk);
    #1 start = 1'b0;
    chk("post_reset_start", busy, 1);
    exp_done = 5;
    wait_done(5, 50, "len2_done");
    settle("len2");

`ifdef KERNEL_READER_ABORT_EN
    // Abort while word 3 is presented with ready high.
    push_words(3, 8);
    start_pulse(6'd8);
    repeat (4) @(posedge clk);
    #1 abort_tb = 1'b1;
    @(posedge clk);
    #1 abort_tb = 1'b0;
    chk("abort_valid", out_valid, 0);
    chk("abort_last", out_last, 0);
    chk("abort_busy", busy, 0);
    chk("abort_addr", rd_address, 0);
    settle("abort");
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
